// File: rtl/t_ff_bank_sequencer_if.sv
// Command-side handshake between a command source and the T-FF bank sequencer.
interface t_ff_bank_sequencer_if #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) ();
    logic                  start;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      target;
    logic [PRESCALE_W-1:0] prescale;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  wrap;

    modport master (
        output start, mode, target, prescale, abort,
        input  busy, done, wrap
    );

    modport slave (
        input  start, mode, target, prescale, abort,
        output busy, done, wrap
    );
endinterface

// File: rtl/t_ff_bank_sequencer.sv
// Sequencer that turns a bank of T flip-flops into a prescaled up/down
// counter with load and clear, by choosing the bank's T vector each cycle
// from the fed-back Q outputs.
module t_ff_bank_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                    CLK,
    input  logic                    res,
    t_ff_bank_sequencer_if.slave    cmd,
    input  logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        t,
    output logic                    bank_n_res
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LOAD,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_down;
    logic [WIDTH-1:0]      r_target;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pc;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wrap;
    logic                  r_bank_n_res;

    logic                  w_tick;
    logic                  w_at_target;
    logic                  w_step;
    logic [WIDTH-1:0]      w_up_t;
    logic [WIDTH-1:0]      w_dn_t;

    assign w_tick      = (r_pc == r_prescale);
    assign w_at_target = (q == r_target);
    // The target check comes before any step, so an abort or a match
    // suppresses the toggle in the same cycle.
    assign w_step      = (r_state == S_RUN) && !cmd.abort && !w_at_target && w_tick;

    // Ripple-carry / ripple-borrow toggle masks: bit i flips when every
    // lower bit is 1 (up) or 0 (down).
    assign w_up_t[0] = 1'b1;
    assign w_dn_t[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
            assign w_up_t[gi] = &q[gi-1:0];
            assign w_dn_t[gi] = ~|q[gi-1:0];
        end
    endgenerate

    // T vector: a count step in RUN, the difference vector in LOAD, else zero.
    always_comb begin
        t = '0;
        case (r_state)
            S_RUN:   if (w_step) t = r_down ? w_dn_t : w_up_t;
            S_LOAD:  if (!cmd.abort) t = q ^ r_target;
            default: t = '0;
        endcase
    end

    // Command FSM with registered status outputs and bank reset.
    always_ff @(posedge CLK) begin
        if (res) begin
            r_state      <= S_IDLE;
            r_down       <= 1'b0;
            r_target     <= '0;
            r_prescale   <= '0;
            r_pc         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_bank_n_res <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_bank_n_res <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd.start) begin
                        r_down     <= cmd.mode[0];
                        r_target   <= cmd.target;
                        r_prescale <= cmd.prescale;
                        r_pc       <= '0;
                        r_busy     <= 1'b1;
                        case (cmd.mode)
                            2'b10:   r_state <= S_LOAD;
                            2'b11: begin
                                r_state      <= S_CLEAR;
                                r_bank_n_res <= 1'b0;
                            end
                            default: r_state <= S_RUN;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cmd.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_at_target) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_pc   <= '0;
                        r_wrap <= r_down ? ~|q : &q;
                    end else begin
                        r_pc <= r_pc + PRESCALE_W'(1);
                    end
                end
                S_LOAD, S_CLEAR: begin
                    if (cmd.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.busy   = r_busy;
    assign cmd.done   = r_done;
    assign cmd.wrap   = r_wrap;
    assign bank_n_res = r_bank_n_res;
endmodule

// File: tb/tb_t_ff_bank_sequencer.sv
// Bench for the T-FF bank sequencer: a behavioural T-FF bank closes the loop,
// commands are scored against an arithmetic model of each command's outcome.
module tb_t_ff_bank_sequencer;
    localparam int W    = 4;
    localparam int P    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         res;
    logic [W-1:0] q;
    logic [W-1:0] t;
    logic         bank_n_res;

    always #5 CLK = ~CLK;

    t_ff_bank_sequencer_if #(.WIDTH(W), .PRESCALE_W(P)) cmd ();

    t_ff_bank_sequencer #(.WIDTH(W), .PRESCALE_W(P)) u_dut (
        .CLK        (CLK),
        .res        (res),
        .cmd        (cmd),
        .q          (q),
        .t          (t),
        .bank_n_res (bank_n_res)
    );

    // Behavioural T flip-flop bank with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge bank_n_res) begin
        if (!bank_n_res) q <= '0;
        else             q <= q ^ t;
    end

    typedef struct {
        int mode;
        int q0;
        int tgt;
        int p;
        int cyc;
        int wraps;
        int tnz;
        int nlow;
        int qf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected T vector for the current cycle, from the arithmetic next value.
    function automatic int exp_tvec(input int mode, input int qv, input int tgt);
        case (mode)
            0:       return qv ^ ((qv + 1) & MASK);
            1:       return qv ^ ((qv - 1) & MASK);
            2:       return qv ^ tgt;
            default: return 0;
        endcase
    endfunction

    // Monitor: accumulates per-command observations, scores them on done.
    int   m_cyc, m_wr, m_tnz, m_nlow;
    exp_t m_e;
    initial begin
        m_cyc = 0; m_wr = 0; m_tnz = 0; m_nlow = 0;
        forever begin
            @(negedge CLK);
            if (res || !cmd.busy) begin
                m_cyc = 0; m_wr = 0; m_tnz = 0; m_nlow = 0;
            end else begin
                if (cmd.wrap) m_wr++;
                if (!cmd.done) begin
                    m_cyc++;
                    if (t != 0) m_tnz++;
                    if (!bank_n_res) m_nlow++;
                    if (t != 0 && sb.size() > 0)
                        chk("t_vector", int'(t), exp_tvec(sb[0].mode, int'(q), sb[0].tgt));
                end else begin
                    chk("t_in_done", int'(t), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        m_e = sb.pop_front();
                        $display("cmd mode=%0d q0=%0d tgt=%0d p=%0d -> q=%0d cyc=%0d wraps=%0d steps=%0d",
                                 m_e.mode, m_e.q0, m_e.tgt, m_e.p, q, m_cyc, m_wr, m_tnz);
                        chk("final_q", int'(q), m_e.qf);
                        chk("busy_cycles", m_cyc, m_e.cyc);
                        chk("wrap_count", m_wr, m_e.wraps);
                        chk("step_count", m_tnz, m_e.tnz);
                        chk("bank_res_low", m_nlow, m_e.nlow);
                    end
                end
            end
        end
    end

    // Drive one start strobe once the sequencer is idle.
    task automatic strobe(input int mode, input int tgt, input int p);
        int k;
        @(negedge CLK);
        k = 0;
        while (cmd.busy && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (cmd.busy) chk("idle_timeout", 1, 0);
        cmd.start    = 1'b1;
        cmd.mode     = 2'(mode);
        cmd.target   = W'(tgt);
        cmd.prescale = P'(p);
        @(negedge CLK);
        cmd.start = 1'b0;
    endtask

    // Scored command: compute the outcome from arithmetic, then run it.
    task automatic issue(input int mode, input int tgt, input int p);
        exp_t e;
        int   steps;
        int   k;
        @(negedge CLK);
        while (cmd.busy) @(negedge CLK);
        e.mode = mode; e.q0 = int'(q); e.tgt = tgt; e.p = p;
        steps = 0;
        if (mode == 0) steps = (tgt - e.q0) & MASK;
        if (mode == 1) steps = (e.q0 - tgt) & MASK;
        e.wraps = 0;
        if (mode == 0 && steps > 0 && tgt < e.q0) e.wraps = 1;
        if (mode == 1 && steps > 0 && tgt > e.q0) e.wraps = 1;
        e.cyc  = (mode < 2) ? steps * (p + 1) + 1 : 1;
        e.tnz  = (mode < 2) ? steps : ((mode == 2 && e.q0 != tgt) ? 1 : 0);
        e.nlow = (mode == 3) ? 1 : 0;
        e.qf   = (mode == 3) ? 0 : tgt;
        sb.push_back(e);
        strobe(mode, tgt, p);
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 1, 0);
            sb.delete();
        end
    endtask

    initial begin
        int k;
        res = 1'b1;
        cmd.start = 1'b0; cmd.mode = 2'b00; cmd.target = '0;
        cmd.prescale = '0; cmd.abort = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_t", int'(t), 0);
        chk("rst_busy", int'(cmd.busy), 0);
        chk("rst_done", int'(cmd.done), 0);
        chk("rst_wrap", int'(cmd.wrap), 0);
        chk("rst_bank_n_res", int'(bank_n_res), 0);
        chk("rst_q", int'(q), 0);
        res = 1'b0;
        #1 chk("bank_n_res_still_low", int'(bank_n_res), 0);
        @(negedge CLK);
        chk("bank_n_res_rise", int'(bank_n_res), 1);

        issue(0, 5, 0);     // up 0 -> 5
        issue(3, 0, 0);     // clear
        issue(1, 14, 0);    // down 0 -> 14 through wrap
        issue(3, 0, 0);
        issue(0, 2, 2);     // prescaled up
        issue(2, 3, 0);     // load 3
        issue(2, 10, 0);    // load 10 from 3
        issue(3, 0, 0);     // clear from 10
        issue(0, 0, 0);     // already at target
        issue(1, 0, 1);     // down already at target
        issue(0, 0, 0);
        issue(2, 15, 0);
        issue(0, 0, 1);     // up 15 -> 0, wrap on final step

        for (int i = 0; i < 40; i++)
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                  int'($urandom_range(0, 3)));

        // Abort while counting 0 -> 9 at q=4.
        issue(3, 0, 0);
        strobe(0, 9, 0);
        k = 0;
        while (q != 4 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("reach_q4", int'(q), 4);
        cmd.abort = 1'b1;
        @(negedge CLK);
        cmd.abort = 1'b0;
        $display("abort at q=4 -> busy=%0d q=%0d", cmd.busy, q);
        chk("abort_busy", int'(cmd.busy), 0);
        chk("abort_q", int'(q), 4);
        repeat (3) @(negedge CLK);
        chk("abort_q_hold", int'(q), 4);
        chk("abort_t", int'(t), 0);

        // Reset in the middle of a run.
        strobe(0, 12, 1);
        repeat (3) @(negedge CLK);
        res = 1'b1;
        @(negedge CLK);
        $display("mid-run reset -> busy=%0d q=%0d bank_n_res=%0d", cmd.busy, q, bank_n_res);
        chk("mrst_t", int'(t), 0);
        chk("mrst_busy", int'(cmd.busy), 0);
        chk("mrst_done", int'(cmd.done), 0);
        chk("mrst_wrap", int'(cmd.wrap), 0);
        chk("mrst_bank_n_res", int'(bank_n_res), 0);
        chk("mrst_q", int'(q), 0);
        res = 1'b0;
        @(negedge CLK);
        chk("mrst_bank_n_res_rise", int'(bank_n_res), 1);

        issue(0, 3, 0);     // normal operation after reset
        repeat (3) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/t_ff_bank_sequencer.md
Name: t_ff_bank_sequencer

Overview:
- Sequencer for a WIDTH-bit bank of t_ff instances. The bank shares one clock, has per-bit T inputs, and has an active-low asynchronous bank reset.
- Drives the bank's T vector and bank reset so the bank behaves as a programmable up/down counter with a prescaler. Also supports direct load and clear.
- Reads the bank's Q outputs back to decide each toggle vector.
- Sits between a command source (start/mode/target handshake) and the T-FF bank.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank
- PRESCALE_W, 4, width of the prescale field; one step every prescale+1 RUN cycles

Ports:
- CLK  input  1  rising-edge clock; the same clock as the T-FF bank
- res  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- mode  input  2  command: 00 count up, 01 count down, 10 load, 11 clear
- target  input  WIDTH  end value for count modes; load value for load mode
- prescale  input  PRESCALE_W  step divider for count modes
- abort  input  1  cancels the current command
- q  input  WIDTH  Q outputs of the T-FF bank
- t  output  WIDTH  T inputs of the bank; combinational from state, q and tick
- bank_n_res  output  1  registered active-low reset to the bank
- busy  output  1  registered; high in every state except IDLE
- done  output  1  registered one-cycle pulse on command completion
- wrap  output  1  registered one-cycle pulse when a count step wraps

Behaviour:
- Reset, while res is high: state=IDLE, t=0, busy=0, done=0, wrap=0, bank_n_res=0, prescale counter pc=0.
  - bank_n_res is held low for the whole reset and rises on the first edge with res low.
  - res overrides everything, including mid-command.
- States: IDLE, RUN, LOAD, CLEAR, DONE.
- IDLE:
  - t=0.
  - On start=1, latch mode, target and prescale, then go to RUN (up/down), LOAD or CLEAR.
  - start is ignored in any state other than IDLE.
- RUN:
  - tick = (pc == prescale_latched). pc counts 0..prescale_latched and wraps to 0. pc is cleared on entry to RUN.
  - If q == target_latched: t=0, go to DONE. This check happens before any step, so a start with q already equal to target performs zero steps.
  - Else, if tick, up step: t[0]=1, t[i]=&q[i-1:0].
  - Else, if tick, down step: t[0]=1, t[i]=&(~q[i-1:0]).
  - Otherwise t=0.
- Step timing: the bank and the sequencer update on the same edge, so the sequencer sees the new q on the cycle after each step.
- wrap: registered pulse on the edge of an up step with q=all-ones, or a down step with q=0.
- LOAD: t = q ^ target_latched for exactly one cycle, then go to DONE.
- CLEAR: bank_n_res=0 for exactly one cycle, t=0, then go to DONE with bank_n_res back at 1.
- DONE:
  - t=0, done=1 for one cycle, then go to IDLE.
  - busy falls on the edge leaving DONE.
- abort=1 in RUN, LOAD or CLEAR: go to IDLE on that edge with t=0 in that cycle. No done pulse; bank_n_res returns to 1.
- abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- res and anything else simultaneously: res wins.
- All comparisons are unsigned and WIDTH bits wide. Counting is modulo 2^WIDTH, with no saturation.

Test Plan:
- Reset: hold res=1 for 3 cycles -> t=0, busy=0, done=0, wrap=0, bank_n_res=0; bank q=0 after release; bank_n_res=1 one edge later.
- Up, prescale=0, q=0, target=5:
  - q steps 1,2,3,4,5 on 5 consecutive edges;
  - done pulses once on the cycle after q==5 is seen;
  - no wrap; busy returns to 0 next.
- Down with wrap, WIDTH=4, q=0, target=14: first step t=1111, q becomes 15 and wrap pulses once; next step t=0001, q becomes 14; then done.
- Prescale=2, up from q=0, target=2: steps occur every 3rd RUN cycle (q=1 at RUN cycle 3, q=2 at cycle 6); t=0 in all other cycles.
- Load and clear:
  - Load with q=3, target=10 -> t=1001 for one cycle, q=10, done.
  - Clear with q=10 -> bank_n_res low one cycle, q=0, done.
  - Start with q equal to target in up mode -> zero steps, done.
- Abort and reset mid-run:
  - abort while counting 0 to 9 at q=4 -> IDLE next edge, q stays 4, no done.
  - res asserted mid-run -> all outputs at reset values, q forced to 0.
